// File: rtl/rfft_seq_ctrl_if.sv
// Handshake and control bundle between the rfft_4pt sequencer (master)
// and the datapath / sample source side (slave).
interface rfft_seq_ctrl_if #(
  parameter int ADDR_BIT = 3
);
  logic                    start;
  logic                    in_valid;
  logic                    in_ready;
  logic                    m0;
  logic                    m11;
  logic [1:0]              m12;
  logic [1:0]              m13;
  logic                    m14;
  logic                    m21;
  logic                    m22;
  logic                    m23;
  logic                    m24;
  logic                    bypass_en;
  logic [ADDR_BIT-1:0]     tw_idx;
  logic [2:0]              stage;
  logic [4*ADDR_BIT-1:0]   addr_read;
  logic [4*ADDR_BIT-1:0]   addr_write;
  logic                    wr_en;
  logic                    busy;
  logic                    done;

  modport master (
    input  start, in_valid,
    output in_ready, m0, m11, m12, m13, m14, m21, m22, m23, m24,
           bypass_en, tw_idx, stage, addr_read, addr_write, wr_en, busy, done
  );

  modport slave (
    output start, in_valid,
    input  in_ready, m0, m11, m12, m13, m14, m21, m22, m23, m24,
           bypass_en, tw_idx, stage, addr_read, addr_write, wr_en, busy, done
  );
endinterface

// File: rtl/rfft_seq_ctrl.sv
// Sequencer for the rfft_4pt datapath and its 4-bank memory: loads N samples
// (4 per beat), then runs NUM_STAGES compute passes, each followed by a drain
// of PIPE_LAT cycles so a pass never reads a row the previous pass still writes.
// IDLE holds every output at 0 (the reset state); LOAD and DONE present mux
// set A with the swap bit clear.
module rfft_seq_ctrl #(
  parameter int ADDR_BIT   = 3,
  parameter int N          = 32,
  parameter int NUM_STAGES = 4,
  parameter int PIPE_LAT   = 2
) (
  input  logic             clk,
  input  logic             rst,
  rfft_seq_ctrl_if.master  bus
);
  localparam int MEM_HEIGHT = N / 4;
  localparam int AW         = 4 * ADDR_BIT;
  localparam logic [ADDR_BIT-1:0] CNT_LAST   = ADDR_BIT'(MEM_HEIGHT - 1);
  localparam logic [ADDR_BIT-1:0] DRAIN_LAST = ADDR_BIT'(PIPE_LAT - 1);
  localparam logic [2:0]          K_LAST     = 3'(NUM_STAGES);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_COMPUTE = 3'd2;
  localparam logic [2:0] S_DRAIN   = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  logic [2:0]          state;
  logic [ADDR_BIT-1:0] cnt;
  logic [2:0]          k;
  logic [PIPE_LAT-1:0] pipe_v;
  logic [AW-1:0]       pipe_a [PIPE_LAT];

  logic                active;
  logic                beat;
  logic [ADDR_BIT-1:0] rd_cnt;
  logic [ADDR_BIT-1:0] off_k;
  logic [ADDR_BIT-1:0] row_b10;
  logic [AW-1:0]       addr_read;
  logic                swap;
  logic                dec_m11;
  logic [1:0]          dec_m12;
  logic [1:0]          dec_m13;
  logic                dec_m14;

  assign active = (state == S_COMPUTE) || (state == S_DRAIN);
  assign beat   = (state == S_LOAD) && bus.in_valid;

  // State, row counter and pass number
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    if (rst) begin
      state <= S_IDLE;
      cnt   <= '0;
      k     <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.start) begin
            state <= S_LOAD;
            cnt   <= '0;
          end
        end
        S_LOAD: begin
          if (beat) begin
            if (cnt == CNT_LAST) begin
              state <= S_COMPUTE;
              cnt   <= '0;
              k     <= 3'd1;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        S_COMPUTE: begin
          if (cnt == CNT_LAST) begin
            state <= S_DRAIN;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DRAIN: begin
          if (cnt == DRAIN_LAST) begin
            cnt <= '0;
            if (k < K_LAST) begin
              state <= S_COMPUTE;
              k     <= k + 1'b1;
            end else begin
              state <= S_DONE;
              k     <= '0;
            end
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  // Read-to-write delay line matching the rfft_4pt pipeline
  always_ff @(posedge clk) begin
    // NOTE: the address delay line is a handful of flops, not a RAM, so it is
    // cleared on reset along with its valid bits.
    if (rst) begin
      pipe_v <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_a[i] <= '0;
    end else begin
      pipe_v[0] <= (state == S_COMPUTE);
      pipe_a[0] <= addr_read;
      for (int i = 1; i < PIPE_LAT; i++) begin
        pipe_v[i] <= pipe_v[i-1];
        pipe_a[i] <= pipe_a[i-1];
      end
    end
  end

  // Bank read addresses; DRAIN keeps presenting the last row of the pass
  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the block can infer a latch.
    rd_cnt = (state == S_DRAIN) ? CNT_LAST : cnt;
    off_k  = '0;
    if (k != 3'd0) off_k = ADDR_BIT'(MEM_HEIGHT - (MEM_HEIGHT >> (k - 3'd1)));
    row_b10   = rd_cnt + off_k;
    addr_read = active ? {rd_cnt, rd_cnt, row_b10, row_b10} : '0;
  end

  // Butterfly mux decode for the current row and pass
  always_comb begin
    logic [ADDR_BIT-1:0] f_mask;
    logic                b_bit;
    swap    = 1'b0;
    dec_m11 = 1'b0;
    dec_m12 = 2'd1;
    dec_m13 = 2'd1;
    dec_m14 = 1'b1;
    f_mask  = ~({ADDR_BIT{1'b1}} >> (int'(k) - 1));
    b_bit   = ((rd_cnt >> (ADDR_BIT - int'(k) + 1)) & ADDR_BIT'(1)) != '0;
    if (int'(k) <= ADDR_BIT)
      swap = ((rd_cnt >> (ADDR_BIT - int'(k))) & ADDR_BIT'(1)) != '0;
    if (k == 3'd1 || ((rd_cnt & f_mask) != '0 && !b_bit)) begin
      dec_m12 = 2'd2;                       // set C
      dec_m13 = 2'd0;
    end else if ((rd_cnt & f_mask) != '0) begin
      dec_m11 = 1'b1;                       // set B
      dec_m12 = 2'd0;
      dec_m13 = 2'd2;
    end
  end

  // Output decode from state registers (wr_en in LOAD follows in_valid)
  always_comb begin
    bus.in_ready   = 1'b0;
    bus.m0         = 1'b0;
    bus.m11        = 1'b0;
    bus.m12        = 2'd0;
    bus.m13        = 2'd0;
    bus.m14        = 1'b0;
    bus.m21        = 1'b0;
    bus.m22        = 1'b0;
    bus.m23        = 1'b0;
    bus.m24        = 1'b0;
    bus.bypass_en  = 1'b0;
    bus.tw_idx     = '0;
    bus.stage      = '0;
    bus.addr_read  = '0;
    bus.addr_write = '0;
    bus.wr_en      = 1'b0;
    bus.busy       = (state != S_IDLE);
    bus.done       = (state == S_DONE);
    if (state == S_LOAD || state == S_DONE) begin
      bus.m12 = 2'd1;
      bus.m13 = 2'd1;
      bus.m14 = 1'b1;
      bus.m23 = 1'b1;
      bus.m24 = 1'b1;
    end
    if (state == S_LOAD) begin
      bus.in_ready   = 1'b1;
      bus.wr_en      = beat;
      bus.addr_write = {cnt, cnt, cnt, cnt};
    end
    if (active) begin
      bus.m0         = 1'b1;
      bus.m11        = dec_m11;
      bus.m12        = dec_m12;
      bus.m13        = dec_m13;
      bus.m14        = dec_m14;
      bus.m21        = swap;
      bus.m22        = swap;
      bus.m23        = !swap;
      bus.m24        = !swap;
      bus.bypass_en  = (k < K_LAST);
      bus.tw_idx     = (state == S_COMPUTE) ? cnt : '0;
      bus.stage      = k;
      bus.addr_read  = addr_read;
      bus.addr_write = pipe_a[PIPE_LAT-1];
      bus.wr_en      = pipe_v[PIPE_LAT-1];
    end
  end
endmodule

// File: tb/tb_rfft_seq_ctrl.sv
// Directed bench for rfft_seq_ctrl with default parameters (ADDR_BIT=3, N=32,
// NUM_STAGES=4, PIPE_LAT=2). Cycle c is the interval after the c-th edge
// following the cycle in which start was driven high.
module tb_rfft_seq_ctrl;
  localparam int AB = 3;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  rfft_seq_ctrl_if #(.ADDR_BIT(AB)) bus ();

  rfft_seq_ctrl #(.ADDR_BIT(AB), .N(32), .NUM_STAGES(4), .PIPE_LAT(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // {m11,m12,m13,m14} sets and {m21,m22,m23,m24} swap patterns
  localparam logic [5:0] SET_A = 6'b0_01_01_1;
  localparam logic [5:0] SET_B = 6'b1_00_10_1;
  localparam logic [5:0] SET_C = 6'b0_10_00_1;
  localparam logic [3:0] SW0   = 4'b0011;
  localparam logic [3:0] SW1   = 4'b1100;

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance to the next cycle, drive inputs, let decode settle
  task automatic next_cycle(input logic st, input logic iv);
    @(posedge clk);
    #1;
    bus.start    = st;
    bus.in_valid = iv;
    #1;
  endtask

  function automatic logic [9:0] mux_outs();
    return {bus.m11, bus.m12, bus.m13, bus.m14, bus.m21, bus.m22, bus.m23, bus.m24};
  endfunction

  function automatic logic [45:0] all_outs();
    return {bus.in_ready, bus.m0, mux_outs(), bus.bypass_en, bus.tw_idx, bus.stage,
            bus.addr_read, bus.addr_write, bus.wr_en, bus.busy, bus.done};
  endfunction

  initial begin
    logic [10:0] vpat;
    logic [2:0]  exp_beat;
    logic        v;

    rst          = 1'b1;
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    #1;
    check("reset_outs", all_outs(), '0);
    check("reset_busy", bus.busy, 1'b0);
    next_cycle(1'b0, 1'b1);
    check("idle_no_start", all_outs(), '0);

    // ---- Transform 1: in_valid held, start re-pulsed while busy ----
    next_cycle(1'b1, 1'b1);
    for (int c = 1; c <= 51; c++) begin
      next_cycle((c == 20) || (c == 49), 1'b1);
      check($sformatf("t1_done_c%0d", c), bus.done, (c == 49));
      check($sformatf("t1_busy_c%0d", c), bus.busy, (c <= 49));
      if (c <= 8) begin
        check($sformatf("t1_load_aw_c%0d", c), bus.addr_write, {4{3'(c - 1)}});
        check($sformatf("t1_load_we_c%0d", c), bus.wr_en, 1'b1);
        check($sformatf("t1_load_rdy_c%0d", c), {bus.in_ready, bus.m0}, 2'b10);
        check($sformatf("t1_load_mux_c%0d", c), mux_outs(), {SET_A, SW0});
      end
      case (c)
        9: begin
          check("k1c0_stage", bus.stage, 3'd1);
          check("k1c0_m0_rdy", {bus.m0, bus.in_ready}, 2'b10);
          check("k1c0_we", bus.wr_en, 1'b0);
          check("k1c0_ar", bus.addr_read, 12'o0000);
          check("k1c0_mux", mux_outs(), {SET_C, SW0});
        end
        11: begin
          check("k1c2_ar", bus.addr_read, 12'o2222);
          check("k1c2_we", bus.wr_en, 1'b1);
          check("k1c2_aw", bus.addr_write, 12'o0000);
          check("k1c2_tw", bus.tw_idx, 3'd2);
          check("k1c2_byp", bus.bypass_en, 1'b1);
        end
        13: check("k1c4_mux", mux_outs(), {SET_C, SW1});
        17: begin
          check("k1_drain_ar", bus.addr_read, 12'o7777);
          check("k1_drain_aw", bus.addr_write, 12'o6666);
          check("k1_drain_we", bus.wr_en, 1'b1);
          check("k1_drain_tw", bus.tw_idx, 3'd0);
        end
        19: begin
          check("k2c0_stage", bus.stage, 3'd2);
          check("k2c0_ar", bus.addr_read, 12'o0044);
          check("k2c0_mux", mux_outs(), {SET_A, SW0});
        end
        24: begin
          check("k2c5_ar", bus.addr_read, 12'o5511);
          check("k2c5_mux", mux_outs(), {SET_B, SW0});
        end
        34: begin
          check("k3c5_stage", bus.stage, 3'd3);
          check("k3c5_ar", bus.addr_read, 12'o5533);
          check("k3c5_mux", mux_outs(), {SET_C, SW1});
          check("k3c5_tw", bus.tw_idx, 3'd5);
          check("k3c5_byp", bus.bypass_en, 1'b1);
        end
        39: begin
          check("k4c0_stage", bus.stage, 3'd4);
          check("k4c0_byp", bus.bypass_en, 1'b0);
          check("k4c0_ar", bus.addr_read, 12'o0077);
          check("k4c0_we", bus.wr_en, 1'b0);
        end
        40: begin
          check("k4c1_ar", bus.addr_read, 12'o1100);
          check("k4c1_we", bus.wr_en, 1'b0);
        end
        41: begin
          check("k4c2_we", bus.wr_en, 1'b1);
          check("k4c2_aw", bus.addr_write, 12'o0077);
        end
        42: check("k4c3_mux", mux_outs(), {SET_B, SW0});
        47: begin
          check("k4_drain_ar", bus.addr_read, 12'o7766);
          check("k4_drain0_we", bus.wr_en, 1'b1);
        end
        48: begin
          check("k4_drain1_we", bus.wr_en, 1'b1);
          check("k4_drain1_aw", bus.addr_write, 12'o7766);
          check("k4_drain1_stage", bus.stage, 3'd4);
        end
        49: begin
          check("done_we", bus.wr_en, 1'b0);
          check("done_stage", bus.stage, 3'd0);
          check("done_m0", bus.m0, 1'b0);
          check("done_mux", mux_outs(), {SET_A, SW0});
        end
        50: check("t1_idle_outs", all_outs(), '0);
        default: ;
      endcase
    end

    // ---- Transform 2: in_valid gaps during LOAD ----
    vpat     = 11'b111111_00101;   // cycle 1 in bit 0
    exp_beat = 3'd0;
    next_cycle(1'b1, 1'b0);
    for (int c = 1; c <= 54; c++) begin
      v = (c <= 11) ? vpat[c-1] : 1'b1;
      next_cycle(1'b0, v);
      check($sformatf("t2_done_c%0d", c), bus.done, (c == 52));
      if (c <= 11) begin
        check($sformatf("t2_rdy_c%0d", c), bus.in_ready, 1'b1);
        check($sformatf("t2_we_c%0d", c), bus.wr_en, v);
        if (v) begin
          check($sformatf("t2_aw_c%0d", c), bus.addr_write, {4{exp_beat}});
          exp_beat = exp_beat + 3'd1;
        end
      end
      if (c == 12) begin
        check("t2_compute_stage", bus.stage, 3'd1);
        check("t2_compute_rdy", {bus.m0, bus.in_ready}, 2'b10);
      end
    end

    // ---- Transform 3: reset in the middle of pass 2, then restart ----
    next_cycle(1'b1, 1'b1);
    for (int c = 1; c <= 22; c++) next_cycle(1'b0, 1'b1);
    check("t3_mid_pass2", bus.stage, 3'd2);
    rst = 1'b1;
    next_cycle(1'b0, 1'b1);
    check("t3_rst_outs", all_outs(), '0);
    check("t3_rst_busy_we", {bus.busy, bus.wr_en}, 2'b00);
    rst = 1'b0;
    next_cycle(1'b1, 1'b1);
    for (int c = 1; c <= 50; c++) begin
      next_cycle(1'b0, 1'b1);
      check($sformatf("t3_done_c%0d", c), bus.done, (c == 49));
      if (c == 1) check("t3_first_beat", {bus.wr_en, bus.addr_write}, {1'b1, 12'o0000});
      if (c == 9) check("t3_pass1", {bus.stage, bus.addr_read}, {3'd1, 12'o0000});
      if (c == 19) check("t3_pass2", {bus.stage, bus.addr_read}, {3'd2, 12'o0044});
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
